// File: rtl/bridge_pkg.sv
// Shared types, default sizes and the round-robin search helper used by the
// bridge source arbiter and its picker.
package bridge_pkg;

    // Default bridge geometry: N-bit beats packed into M-bit words.
    localparam int unsigned DEF_N     = 32;
    localparam int unsigned DEF_M     = 128;
    localparam int unsigned DEF_BURST = DEF_M / DEF_N;

    // Upper bound on requesters handled by rr_next (index width MAX_ID_W).
    localparam int unsigned MAX_K     = 32;
    localparam int unsigned MAX_ID_W  = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                hit;
        logic [MAX_ID_W-1:0] idx;
    } rr_result_t;

    // First set bit of vld in the order ptr+1, ptr+2, ... wrapping modulo k.
    // ptr itself is visited last, so it only wins when nothing else is set.
    function automatic rr_result_t rr_next(
        input logic [MAX_K-1:0] vld,
        input int unsigned      ptr,
        input int unsigned      k
    );
        rr_result_t  res;
        int unsigned cand;
        res = '0;
        for (int unsigned i = 32'd1; i <= MAX_K; i++) begin
            if (i <= k) begin
                cand = ((ptr + i) >= k) ? (ptr + i - k) : (ptr + i);
                if (vld[cand[MAX_ID_W-1:0]] && !res.hit) begin
                    res.hit = 1'b1;
                    res.idx = cand[MAX_ID_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bridge_src_arbiter_if.sv
// Requester-side and bridge-side handshake bundle of the source arbiter.
// The arbiter uses the slave view; the requesters/bridge side uses master.
interface bridge_src_arbiter_if
    import bridge_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned K    = 4,
    parameter int unsigned ID_W = 2
);

    logic [K-1:0]   in_vld;
    logic [K*N-1:0] in_data;
    logic [K-1:0]   in_rdy;
    logic           out_vld;
    logic [N-1:0]   out_data;
    logic [ID_W-1:0] out_src;
    logic           out_last;
    logic           out_rdy;

    modport slave (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_data, out_src, out_last
    );

    modport master (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_data, out_src, out_last
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin search over a K-bit request vector, starting
// just after ptr. Shared between idle arbitration and end-of-burst handover.
module rr_picker
    import bridge_pkg::*;
#(
    parameter int unsigned K    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [K-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            hit,
    output logic [ID_W-1:0] idx
);

    rr_result_t res;
    logic       unused_res;

    // Evaluate the package search and narrow the index to this instance's width.
    always_comb begin
        res = rr_next(MAX_K'(req), 32'(ptr), K);
        hit = res.hit;
        idx = res.idx[ID_W-1:0];
    end

    // Upper index bits are always zero when ID_W is below MAX_ID_W.
    assign unused_res = ^res;

endmodule

// File: rtl/bridge_src_arbiter.sv
// Round-robin source arbiter in front of the N-to-M packing bridge. A grant
// is held for BURST accepted beats so each packed word comes from one source;
// at the end of a burst the next source is chosen in the same cycle.
module bridge_src_arbiter
    import bridge_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned K     = 4,
    parameter int unsigned BURST = DEF_BURST,
    parameter int unsigned ID_W  = (K > 1) ? $clog2(K) : 1,
    parameter int unsigned CNT_W = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic                clk,
    input  logic                rst,
    bridge_src_arbiter_if.slave bus,
    output logic                busy
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);
    localparam logic [ID_W-1:0]  PTR_RST   = ID_W'(K - 1);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [ID_W-1:0]  gnt_q;
    logic [ID_W-1:0]  last_q;
    logic [CNT_W-1:0] beat_q;

    logic [ID_W-1:0]  pick_ptr;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_hit;
    logic             gnt_vld;
    logic             xfer;
    logic             at_last;
    logic             end_burst;

    // Live handshake terms for the held grant and the picker start point.
    always_comb begin
        if (state_q == LOCK) begin
            gnt_vld  = bus.in_vld[gnt_q];
            at_last  = (beat_q == LAST_BEAT);
            pick_ptr = gnt_q;
        end else begin
            gnt_vld  = 1'b0;
            at_last  = 1'b0;
            pick_ptr = last_q;
        end
        xfer      = gnt_vld & bus.out_rdy;
        end_burst = xfer & at_last;
    end

    // Single picker: from last_q when idle, from the current grant at burst end
    // (the current source is searched last, so it only keeps the grant alone).
    rr_picker #(
        .K    (K),
        .ID_W (ID_W)
    ) u_picker (
        .req (bus.in_vld),
        .ptr (pick_ptr),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: grab a grant when idle, release only if nobody requests.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    state_d = LOCK;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCK: begin
                if (end_burst && !pick_hit) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant, round-robin pointer and beat counter; frozen while no beat moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q  <= '0;
            last_q <= PTR_RST;
            beat_q <= '0;
        end else begin
            if (state_q == IDLE) begin
                if (pick_hit) begin
                    gnt_q  <= pick_idx;
                    beat_q <= '0;
                end
            end else if (end_burst) begin
                last_q <= gnt_q;
                beat_q <= '0;
                if (pick_hit) begin
                    gnt_q <= pick_idx;
                end
            end else if (xfer) begin
                beat_q <= beat_q + CNT_W'(1);
            end
        end
    end

    // Outputs: muxes of the registered grant and live inputs, no bubble on handover.
    always_comb begin
        bus.in_rdy   = '0;
        bus.out_vld  = 1'b0;
        bus.out_data = '0;
        bus.out_src  = '0;
        bus.out_last = 1'b0;
        busy         = 1'b0;
        case (state_q)
            LOCK: begin
                bus.in_rdy[gnt_q] = bus.out_rdy;
                bus.out_vld       = gnt_vld;
                bus.out_data      = bus.in_data[gnt_q*N +: N];
                bus.out_src       = gnt_q;
                bus.out_last      = at_last;
                busy              = 1'b1;
            end
            IDLE: begin
                busy = 1'b0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bridge_src_arbiter.sv
// Randomised bench for bridge_src_arbiter: requesters fed from per-source
// data tables, outputs compared every cycle against a burst-level model.
module tb_bridge_src_arbiter;

    localparam int unsigned N     = 32;
    localparam int unsigned K     = 4;
    localparam int unsigned BURST = 4;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned DEPTH = 128;
    localparam int unsigned VW    = 1 + K + 1 + ID_W + 1 + N;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    bridge_src_arbiter_if #(.N(N), .K(K), .ID_W(ID_W)) bus ();

    bridge_src_arbiter #(.N(N), .K(K), .BURST(BURST)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Requester data tables: source i sends src_mem[i][head..fill-1] in order.
    logic [N-1:0] src_mem [K][DEPTH];
    int           head [K];
    int           fill [K];
    logic [K-1:0] en;
    logic         rdy;
    logic [K-1:0] drv_vld;
    logic [N-1:0] drv_data [K];

    // Reference model: grant holder, beats done in this burst, last winner.
    bit m_busy;
    int m_gnt;
    int m_beat;
    int m_last;

    logic [VW-1:0] exp_vec;
    logic [VW-1:0] obs_vec;

    // Log of observed transfers: source, last flag, data, cycle.
    int           xs [$];
    bit           xl [$];
    logic [N-1:0] xd [$];
    int           xc [$];

    function automatic int rr_pick(input logic [K-1:0] v, input int start);
        for (int off = 1; off <= K; off++) begin
            int j;
            j = (start + off) % K;
            if (v[j]) return j;
        end
        return start;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_gnt  = 0;
        m_beat = 0;
        m_last = K - 1;
    endtask

    task automatic clear_logs();
        xs.delete(); xl.delete(); xd.delete(); xc.delete();
        cyc = 0;
    endtask

    task automatic fill_queues(input logic [K-1:0] which, input int n);
        for (int i = 0; i < K; i++) begin
            if (which[i]) begin
                for (int k = 0; k < n; k++) src_mem[i][fill[i] + k] = $urandom;
                fill[i] += n;
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < K; i++) begin
            drv_vld[i]  = en[i] && (head[i] < fill[i]);
            drv_data[i] = drv_vld[i] ? src_mem[i][head[i]] : '0;
            bus.in_data[i*N +: N] = drv_data[i];
        end
        bus.in_vld  = drv_vld;
        bus.out_rdy = rdy;
    endtask

    task automatic predict();
        logic [K-1:0]    e_rdy;
        logic [ID_W-1:0] e_src;
        logic [N-1:0]    e_data;
        logic            e_vld;
        logic            e_last;
        e_rdy  = '0;
        e_src  = '0;
        e_data = '0;
        e_vld  = 1'b0;
        e_last = 1'b0;
        if (m_busy) begin
            e_rdy[m_gnt] = rdy;
            e_src  = ID_W'(m_gnt);
            e_data = drv_data[m_gnt];
            e_vld  = drv_vld[m_gnt];
            e_last = (m_beat == BURST - 1);
        end
        exp_vec = {m_busy, e_rdy, e_vld, e_src, e_last, e_data};
    endtask

    task automatic observe();
        obs_vec = {busy, bus.in_rdy, bus.out_vld, bus.out_src, bus.out_last, bus.out_data};
    endtask

    // Called at posedge+1: apply inputs, settle, form expected and observed.
    task automatic cycle_begin();
        drive();
        #1;
        predict();
        observe();
    endtask

    // Log the transfer, let requesters pop, take the edge, advance the model.
    task automatic cycle_end();
        if (bus.out_vld && bus.out_rdy) begin
            xs.push_back(int'(bus.out_src));
            xl.push_back(bus.out_last);
            xd.push_back(bus.out_data);
            xc.push_back(cyc);
        end
        for (int i = 0; i < K; i++) begin
            if (bus.in_rdy[i] && bus.in_vld[i]) head[i]++;
        end
        @(posedge clk);
        if (!m_busy) begin
            if (drv_vld != '0) begin
                m_busy = 1'b1;
                m_gnt  = rr_pick(drv_vld, m_last);
                m_beat = 0;
            end
        end else if (drv_vld[m_gnt] && rdy) begin
            m_beat++;
            if (m_beat == BURST) begin
                m_last = m_gnt;
                m_beat = 0;
                if (drv_vld != '0) m_gnt = rr_pick(drv_vld, m_gnt);
                else m_busy = 1'b0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic reset_assert();
        rst = 1'b1;
        en  = '0;
        rdy = 1'b0;
        for (int i = 0; i < K; i++) begin
            head[i] = 0;
            fill[i] = 0;
        end
        model_reset();
        clear_logs();
        drive();
    endtask

    task automatic reset_release();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clear_logs();
    endtask

    task automatic test_reset();
        reset_assert();
        fill_queues(4'b1111, 8);
        en  = 4'b1111;
        rdy = 1'b1;
        drive();
        #1;
        observe();
        vectors++;
        if (obs_vec !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want 0", obs_vec);
        end
        reset_release();
        for (int c = 0; c < 10; c++) begin
            cycle_begin();
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_cycle %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
            cycle_end();
        end
        vectors++;
        if (xs.size() != 9 || xc[0] != 1) begin
            miscompares++;
            $display("FAIL reset_latency: got %0d xfers first@%0d want 9 first@1", xs.size(), xc[0]);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (xs[k] != 0 || xl[k] != (k == 3) || xd[k] !== src_mem[0][k]) begin
                miscompares++;
                $display("FAIL reset_beat %0d: got src %0d last %0d data %h want src 0 last %0d data %h",
                         k, xs[k], xl[k], xd[k], (k == 3), src_mem[0][k]);
            end
        end
        vectors++;
        if (xs[4] != 1 || xc[4] != xc[3] + 1) begin
            miscompares++;
            $display("FAIL reset_handover: got src %0d gap %0d want src 1 gap 1", xs[4], xc[4] - xc[3]);
        end
    endtask

    task automatic test_fairness();
        int guard;
        int cnt [K];
        reset_assert();
        fill_queues(4'b1111, 16);
        reset_release();
        en  = 4'b1111;
        rdy = 1'b1;
        guard = 0;
        while (xs.size() < 64 && guard < 200) begin
            cycle_begin();
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL fair_cycle %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
            cycle_end();
            guard++;
        end
        vectors++;
        if (xs.size() < 64) begin
            miscompares++;
            $display("FAIL fair_timeout: got %0d beats want 64", xs.size());
        end
        for (int b = 0; b < 16; b++) begin
            vectors++;
            if (xs[4*b] != b % 4 || xs[4*b+3] != b % 4 || !xl[4*b+3]) begin
                miscompares++;
                $display("FAIL fair_order burst %0d: got src %0d want %0d", b, xs[4*b], b % 4);
            end
        end
        for (int i = 0; i < K; i++) cnt[i] = 0;
        for (int t = 0; t < xs.size(); t++) begin
            vectors++;
            if (xd[t] !== src_mem[xs[t]][cnt[xs[t]]]) begin
                miscompares++;
                $display("FAIL fair_data beat %0d: got %h want %h", t, xd[t], src_mem[xs[t]][cnt[xs[t]]]);
            end
            cnt[xs[t]]++;
        end
        for (int i = 0; i < K; i++) begin
            vectors++;
            if (cnt[i] != 16) begin
                miscompares++;
                $display("FAIL fair_share req %0d: got %0d beats want 16", i, cnt[i]);
            end
        end
    endtask

    task automatic test_lock();
        int guard;
        int n2;
        int n0;
        reset_assert();
        fill_queues(4'b1111, 8);
        reset_release();
        en  = 4'b1111;
        rdy = 1'b1;
        guard = 0;
        n2 = 0;
        while (n2 < 2 && guard < 100) begin
            cycle_begin();
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL lock_cycle %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
            cycle_end();
            n2 = 0;
            foreach (xs[t]) if (xs[t] == 2) n2++;
            guard++;
        end
        n0 = xs.size();
        en[2] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cycle_begin();
            vectors++;
            if (obs_vec !== exp_vec || busy !== 1'b1 || bus.out_vld !== 1'b0 ||
                bus.out_src !== 2'd2 || bus.in_rdy !== 4'b0100) begin
                miscompares++;
                $display("FAIL lock_hold %0d: got %h want %h (busy 1 vld 0 src 2)", c, obs_vec, exp_vec);
            end
            cycle_end();
        end
        en[2] = 1'b1;
        guard = 0;
        while (xs.size() < n0 + 3 && guard < 50) begin
            cycle_begin();
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL lock_cycle %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
            cycle_end();
            guard++;
        end
        vectors++;
        if (xs.size() < n0 + 3 || xs[n0] != 2 || xs[n0+1] != 2 || !xl[n0+1] || xs[n0+2] != 3) begin
            miscompares++;
            $display("FAIL lock_resume: got srcs %0d,%0d,%0d want 2,2,3", xs[n0], xs[n0+1], xs[n0+2]);
        end
    endtask

    task automatic test_backpressure();
        int cnt [K];
        logic [3:0] pat;
        pat = 4'b1001;
        reset_assert();
        fill_queues(4'b1111, 48);
        reset_release();
        en = 4'b1111;
        for (int c = 0; c < 160; c++) begin
            rdy = (c < 40) ? pat[c % 4] : 1'($urandom_range(0, 1));
            cycle_begin();
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL bp_cycle %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
            cycle_end();
        end
        for (int i = 0; i < K; i++) cnt[i] = 0;
        for (int t = 0; t < xs.size(); t++) begin
            vectors++;
            if (xd[t] !== src_mem[xs[t]][cnt[xs[t]]]) begin
                miscompares++;
                $display("FAIL bp_data beat %0d: got %h want %h", t, xd[t], src_mem[xs[t]][cnt[xs[t]]]);
            end
            cnt[xs[t]]++;
        end
        for (int i = 0; i < K; i++) begin
            vectors++;
            if (cnt[i] != head[i]) begin
                miscompares++;
                $display("FAIL bp_count req %0d: got %0d delivered want %0d accepted", i, cnt[i], head[i]);
            end
        end
    endtask

    task automatic test_single();
        int guard;
        reset_assert();
        fill_queues(4'b1000, 24);
        reset_release();
        en  = 4'b1000;
        rdy = 1'b1;
        guard = 0;
        while (xs.size() < 20 && guard < 100) begin
            if (xs.size() >= 14 && en[1] == 1'b0) begin
                fill_queues(4'b0010, 8);
                en[1] = 1'b1;
            end
            cycle_begin();
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL single_cycle %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
            cycle_end();
            guard++;
        end
        vectors++;
        if (xs.size() < 20) begin
            miscompares++;
            $display("FAIL single_timeout: got %0d beats want 20", xs.size());
        end
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (xs[k] != 3 || (k > 0 && xc[k] != xc[k-1] + 1)) begin
                miscompares++;
                $display("FAIL single_regrant beat %0d: got src %0d want 3 back-to-back", k, xs[k]);
            end
        end
        vectors++;
        if (xs[16] != 1 || xc[16] != xc[15] + 1) begin
            miscompares++;
            $display("FAIL single_switch: got src %0d want 1", xs[16]);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        reset_assert();
        fill_queues(4'b1111, 8);
        reset_release();
        en  = 4'b1111;
        rdy = 1'b1;
        guard = 0;
        while (xs.size() < 6 && guard < 50) begin
            cycle_begin();
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL rmid_cycle %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
            cycle_end();
            guard++;
        end
        drive();
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || bus.in_rdy !== 4'b0000 || bus.out_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_abort: got busy %b rdy %b vld %b want 0 0000 0", busy, bus.in_rdy, bus.out_vld);
        end
        reset_release();
        for (int c = 0; c < 6; c++) begin
            cycle_begin();
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL rmid_cycle %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
            cycle_end();
        end
        vectors++;
        if (xs.size() < 1 || xs[0] != 0) begin
            miscompares++;
            $display("FAIL rmid_priority: got src %0d want 0", xs[0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_fairness();
        test_lock();
        test_backpressure();
        test_single();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bridge_src_arbiter.md
# bridge_src_arbiter

Round-robin arbiter that shares the single N-to-M packing bridge among K requesters. Each grant is locked for a fixed burst of BURST input beats, so that one M-bit output word of the bridge is assembled from a single source, with default BURST = M/N = 4. The arbiter sits directly upstream of the bridge's input valid/ready port. It also emits a source ID and an end-of-burst marker alongside each beat.

## Interface
- `N`, default 32: beat width in bits, equal to the bridge input width.
- `K`, default 4: number of requesters, K ≥ 1.
- `BURST`, default 4: beats per grant, BURST ≥ 1; set to M/N for the bridge.
- `ID_W`, default max(1, $clog2(K)): source-ID width.
- `CNT_W`, default max(1, $clog2(BURST)): beat-counter width.

Ports:
- `clk`  in  1: clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_vld`  in  K: per-requester valid.
- `in_data`  in  K*N: requester i occupies bits [i*N +: N].
- `in_rdy`  out  K: per-requester ready, one-hot or zero.
- `out_vld`  out  1: beat valid toward the bridge.
- `out_data`  out  N: beat data from the granted requester.
- `out_src`  out  ID_W: index of the granted requester.
- `out_last`  out  1: asserted on the final beat of the burst.
- `out_rdy`  in  1: bridge ready.
- `busy`  out  1: a grant is held (state LOCK).

## Operation
- States are IDLE (no grant) and LOCK (grant held on `gnt_q`).
- Round-robin pointer `last_q` holds the index of the last requester granted. Search order is last_q+1, last_q+2, …, wrapping modulo K. The pointer resets to K-1, so requester 0 has top priority after reset.
- **IDLE:** if any `in_vld` is set, register grant = first hit in search order, load `beat_q = 0`, go to LOCK. `in_rdy` is 0 in IDLE; no beat is transferred.
- **LOCK:**
  - `out_vld = in_vld[gnt_q]`, `out_data = in_data[gnt_q]`, `in_rdy[gnt_q] = out_rdy`; all other `in_rdy` are 0.
  - A beat transfers when `out_vld & out_rdy`. On transfer, `beat_q` increments.
  - `out_last = (beat_q == BURST-1)`.
- **End of burst** (transfer with `out_last`):
  - Re-arbitrate in the same cycle using current `in_vld`, searching from gnt_q+1. The current source is eligible only if no other source requests.
  - On a hit: load the new grant, `last_q <= gnt_q`, `beat_q <= 0`, stay in LOCK. There is no bubble.
  - On no hit: `last_q <= gnt_q`, go to IDLE.
- **No preemption.** If the granted source drops `in_vld` mid-burst, the grant is held, `out_vld` = 0, and no other source may interject.
- Requesters must hold `in_vld` and `in_data` stable until accepted. The arbiter neither buffers nor drops beats.
- **K=1:** `out_src` is constant 0; bursts are still counted.
- **BURST=1:** every transfer re-arbitrates.

## Timing
- Reset values: `in_rdy` = 0, `out_vld` = 0, `out_last` = 0, `out_src` = 0, `busy` = 0, state IDLE, `beat_q = 0`, `last_q = K-1`.
- Latency from IDLE: request at cycle t gives grant at t+1; first beat can transfer at t+1.
- Back-to-back bursts: the first beat of the new burst can transfer in the cycle after the last beat.
- Output paths are combinational: `out_vld`, `out_data` and `in_rdy` are muxes of registered grant and live inputs. `out_rdy` → `in_rdy` is a combinational path, with no loop through `out_vld`.
- `out_src` and `out_last` are valid whenever `out_vld` = 1. `out_src` holds `gnt_q` while in LOCK.
- `out_rdy` low freezes `beat_q` and the grant indefinitely.
- `rst` mid-burst: immediate return to IDLE and the partial burst is abandoned. The bridge must share `rst` so its partial word is also cleared.

## Structure
- `bridge_pkg` holds:
  - the `arb_state_t` enum {IDLE, LOCK};
  - the default N, M and BURST constants;
  - the function `rr_next(vld, ptr)` returning {hit, index}.
- Sub-module `rr_picker`: combinational round-robin search over a K-bit request vector from a start pointer. It is instantiated once and used both for IDLE arbitration and for end-of-burst re-arbitration.

## Test plan
- **Reset default:** after reset, `in_vld` = 4'b1111 → requester 0 granted at cycle 1. Then 4 beats with `out_src` = 0 and `out_last` on beat 4. Next grant is requester 1 with no idle cycle.
- **Fairness:** all four requesters held valid for 16 bursts → grant order 0,1,2,3,0,…; each requester gets exactly 4 bursts, 16 beats each.
- **Lock:** requester 2 drops `in_vld` after beat 2 while 0 and 1 request → `out_vld` = 0 and grant stays 2. Beats 3–4 come from requester 2 when it reasserts; only then is requester 3 (or the next in order) granted.
- **Backpressure:** `out_rdy` toggled 1,0,0,1,… → `beat_q` advances only on transfer cycles. `in_rdy` mirrors `out_rdy` for the granted source only; data is never duplicated or lost, checked against a scoreboard.
- **Single requester:** only requester 3 active for 3 bursts → it is re-granted back-to-back. Then requester 1 asserts mid-burst → requester 1 is granted next.
- **Reset mid-burst:** `rst` asserted after beat 2 → in the same cycle `busy` = 0, `in_rdy` = 0, `out_vld` = 0. After release, requester 0 has priority again.
